uart_core: RTL and testbench

- Single-clock, parametrised full-duplex UART: TX with valid/ready handshake, RX with mid-bit sampling, parity and framing checks.
- Replaces the fixed 8N1, dual-clock transmitter/receiver pair.
- Sits between the serial pins and byte-stream producers/consumers, such as the message sequencer and LED/debug sinks.
- Internal loopback mode for self-test.

---
 rtl/uart_core_if.sv | 32 +++
 rtl/uart_core.sv | 239 +++++++++++++++++++++++
 tb/tb_uart_core.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_core_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_core_if
// Brief    : Byte-stream side of uart_core. The TX valid/ready handshake and
//            the RX result strobe with its error flags.
// Revision : 1.0  initial release
// ============================================================================
interface uart_core_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 tx_busy;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_parity_err;
    logic                 rx_frame_err;

    // Producer/consumer side
    modport master (
        output tx_data, tx_valid,
        input  tx_ready, tx_busy, rx_data, rx_valid, rx_parity_err, rx_frame_err
    );

    // UART side
    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, tx_busy, rx_data, rx_valid, rx_parity_err, rx_frame_err
    );
endinterface
`default_nettype wire

// File: rtl/uart_core.sv
`default_nettype none
// ============================================================================
// Module   : uart_core
// Brief    : Single-clock full-duplex UART. TX has a valid/ready handshake
//            and supports back-to-back frames. RX samples mid-bit and checks
//            parity and the first stop bit. Optional internal loopback.
// Revision : 1.0  initial release
// ============================================================================
module uart_core #(
    parameter int CLOCKS_PER_BIT = 4,
    parameter int DATA_BITS      = 8,
    parameter int PARITY         = 0,
    parameter int STOP_BITS      = 1
) (
    input  wire logic     clk,
    input  wire logic     rst,
    uart_core_if.slave    bus,
    output logic          ser_tx,
    input  wire logic     ser_rx,
    input  wire logic     loopback
);

    localparam int                  c_BAUD_W    = $clog2(CLOCKS_PER_BIT);
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLOCKS_PER_BIT - 1);
    localparam logic [c_BAUD_W-1:0] c_HALF_LAST = c_BAUD_W'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [c_BAUD_W-1:0] c_BAUD_ONE  = c_BAUD_W'(1);
    localparam logic [3:0]          c_DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]          c_STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic                c_ODD       = 1'(PARITY == 1);

    // ------------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_TX_IDLE   = 3'd0;
    localparam logic [2:0] c_TX_START  = 3'd1;
    localparam logic [2:0] c_TX_DATA   = 3'd2;
    localparam logic [2:0] c_TX_PARITY = 3'd3;
    localparam logic [2:0] c_TX_STOP   = 3'd4;

    logic [2:0]           r_tx_state;
    logic [2:0]           w_tx_next;
    logic [c_BAUD_W-1:0]  r_tx_baud;
    logic [3:0]           r_tx_bit;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx_par;
    logic                 w_tx_baud_done;
    logic                 w_tx_end;
    logic                 w_tx_ready;
    logic                 w_tx_accept;
    logic                 w_ser_tx;

    assign w_tx_baud_done = (r_tx_baud == c_BAUD_LAST);
    // Last cycle of the last stop bit: a new frame may be accepted here so
    // its start bit follows without an idle gap.
    assign w_tx_end       = (r_tx_state == c_TX_STOP) && w_tx_baud_done && (r_tx_bit == c_STOP_LAST);
    assign w_tx_ready     = !rst && ((r_tx_state == c_TX_IDLE) || w_tx_end);
    assign w_tx_accept    = bus.tx_valid && w_tx_ready;

    // TX state register
    always_ff @(posedge clk) begin
        if (rst) r_tx_state <= c_TX_IDLE;
        else     r_tx_state <= w_tx_next;
    end

    // TX next-state decode; each non-idle state advances on bit boundaries
    always_comb begin
        w_tx_next = r_tx_state;
        case (r_tx_state)
            c_TX_IDLE:   if (w_tx_accept) w_tx_next = c_TX_START;
            c_TX_START:  if (w_tx_baud_done) w_tx_next = c_TX_DATA;
            c_TX_DATA:   if (w_tx_baud_done && (r_tx_bit == c_DATA_LAST))
                             w_tx_next = (PARITY != 0) ? c_TX_PARITY : c_TX_STOP;
            c_TX_PARITY: if (w_tx_baud_done) w_tx_next = c_TX_STOP;
            c_TX_STOP:   if (w_tx_end) w_tx_next = w_tx_accept ? c_TX_START : c_TX_IDLE;
            default:     w_tx_next = c_TX_IDLE;
        endcase
    end

    // TX baud/bit counters and payload shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_baud  <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
        end else begin
            if ((r_tx_state == c_TX_IDLE) || w_tx_baud_done) r_tx_baud <= '0;
            else                                              r_tx_baud <= r_tx_baud + c_BAUD_ONE;

            // Bit index restarts on every state change, counts data and stop bits
            if (w_tx_next != r_tx_state) r_tx_bit <= '0;
            else if (w_tx_baud_done)     r_tx_bit <= r_tx_bit + 4'd1;

            if (w_tx_accept) begin
                r_tx_shift <= bus.tx_data;
                r_tx_par   <= (^bus.tx_data) ^ c_ODD;
            end else if ((r_tx_state == c_TX_DATA) && w_tx_baud_done) begin
                r_tx_shift <= r_tx_shift >> 1;
            end
        end
    end

    // TX outputs: line level per state, idle high
    always_comb begin
        w_ser_tx = 1'b1;
        case (r_tx_state)
            c_TX_START:  w_ser_tx = 1'b0;
            c_TX_DATA:   w_ser_tx = r_tx_shift[0];
            c_TX_PARITY: w_ser_tx = r_tx_par;
            default:     w_ser_tx = 1'b1;
        endcase
    end

    assign ser_tx       = w_ser_tx;
    assign bus.tx_ready = w_tx_ready;
    assign bus.tx_busy  = (r_tx_state != c_TX_IDLE);

    // ------------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_RX_IDLE      = 3'd0;
    localparam logic [2:0] c_RX_START     = 3'd1;
    localparam logic [2:0] c_RX_DATA      = 3'd2;
    localparam logic [2:0] c_RX_PARITY    = 3'd3;
    localparam logic [2:0] c_RX_STOP      = 3'd4;
    localparam logic [2:0] c_RX_WAIT_HIGH = 3'd5;

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 w_rx_in;
    logic                 w_rx_s;
    logic [2:0]           r_rx_state;
    logic [2:0]           w_rx_next;
    logic [c_BAUD_W-1:0]  r_rx_baud;
    logic [3:0]           r_rx_bit;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic                 r_rx_par_bit;
    logic                 w_rx_half;
    logic                 w_rx_full;
    logic                 w_rx_done;
    logic                 w_rx_par_err;
    logic                 w_rx_frame_err;
    logic                 r_rx_valid;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_par_err;
    logic                 r_rx_frame_err;

    assign w_rx_in   = loopback ? w_ser_tx : ser_rx;
    assign w_rx_s    = r_sync2;
    assign w_rx_half = (r_rx_baud == c_HALF_LAST);
    assign w_rx_full = (r_rx_baud == c_BAUD_LAST);

    // Two-flop synchroniser; idles high so reset does not look like a start bit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= w_rx_in;
            r_sync2 <= r_sync1;
        end
    end

    // RX state register
    always_ff @(posedge clk) begin
        if (rst) r_rx_state <= c_RX_IDLE;
        else     r_rx_state <= w_rx_next;
    end

    // RX next-state decode; the start bit is re-checked at its midpoint
    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            c_RX_IDLE:      if (!w_rx_s) w_rx_next = c_RX_START;
            c_RX_START:     if (w_rx_half) w_rx_next = w_rx_s ? c_RX_IDLE : c_RX_DATA;
            c_RX_DATA:      if (w_rx_full && (r_rx_bit == c_DATA_LAST))
                                w_rx_next = (PARITY != 0) ? c_RX_PARITY : c_RX_STOP;
            c_RX_PARITY:    if (w_rx_full) w_rx_next = c_RX_STOP;
            c_RX_STOP:      if (w_rx_full) w_rx_next = w_rx_s ? c_RX_IDLE : c_RX_WAIT_HIGH;
            c_RX_WAIT_HIGH: if (w_rx_s) w_rx_next = c_RX_IDLE;
            default:        w_rx_next = c_RX_IDLE;
        endcase
    end

    // RX baud/bit counters, payload and parity capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_baud    <= '0;
            r_rx_bit     <= '0;
            r_rx_shift   <= '0;
            r_rx_par_bit <= 1'b0;
        end else begin
            // Restarting on every state change re-aligns to each start edge
            if ((w_rx_next != r_rx_state) || w_rx_full ||
                (r_rx_state == c_RX_IDLE) || (r_rx_state == c_RX_WAIT_HIGH))
                r_rx_baud <= '0;
            else
                r_rx_baud <= r_rx_baud + c_BAUD_ONE;

            if (w_rx_next != r_rx_state)                   r_rx_bit <= '0;
            else if ((r_rx_state == c_RX_DATA) && w_rx_full) r_rx_bit <= r_rx_bit + 4'd1;

            if ((r_rx_state == c_RX_DATA) && w_rx_full)
                r_rx_shift <= {w_rx_s, r_rx_shift[DATA_BITS-1:1]};

            if ((r_rx_state == c_RX_PARITY) && w_rx_full)
                r_rx_par_bit <= w_rx_s;
        end
    end

    // RX outputs: frame-complete strobe and error evaluation at the stop sample
    always_comb begin
        w_rx_done      = (r_rx_state == c_RX_STOP) && w_rx_full;
        w_rx_par_err   = (PARITY != 0) && (r_rx_par_bit != ((^r_rx_shift) ^ c_ODD));
        w_rx_frame_err = !w_rx_s;
    end

    // RX result register: one-cycle pulse, data held between pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_valid     <= 1'b0;
            r_rx_data      <= '0;
            r_rx_par_err   <= 1'b0;
            r_rx_frame_err <= 1'b0;
        end else begin
            r_rx_valid     <= w_rx_done;
            r_rx_par_err   <= w_rx_done && w_rx_par_err;
            r_rx_frame_err <= w_rx_done && w_rx_frame_err;
            if (w_rx_done) r_rx_data <= r_rx_shift;
        end
    end

    assign bus.rx_valid      = r_rx_valid;
    assign bus.rx_data       = r_rx_data;
    assign bus.rx_parity_err = r_rx_par_err;
    assign bus.rx_frame_err  = r_rx_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_core
// Brief    : Scoreboard bench for uart_core. Three instances: 8N1 at 4 clk/bit,
//            8E1 at 4 clk/bit, 8N1 at 8 clk/bit. Expected RX results are
//            queued as stimulus is issued; a monitor pops them on rx_valid.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [2:0] ser_rx_v;
    logic [2:0] loop_v;
    logic       ser_tx0, ser_tx1, ser_tx2;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [9:0] q0[$], q1[$], q2[$];

    always @(posedge clk) cyc <= cyc + 1;

    uart_core_if #(.DATA_BITS(8)) bus0 ();
    uart_core_if #(.DATA_BITS(8)) bus1 ();
    uart_core_if #(.DATA_BITS(8)) bus2 ();

    uart_core #(.CLOCKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .ser_tx(ser_tx0), .ser_rx(ser_rx_v[0]), .loopback(loop_v[0]));
    uart_core #(.CLOCKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .ser_tx(ser_tx1), .ser_rx(ser_rx_v[1]), .loopback(loop_v[1]));
    uart_core #(.CLOCKS_PER_BIT(8), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut2 (
        .clk(clk), .rst(rst), .bus(bus2), .ser_tx(ser_tx2), .ser_rx(ser_rx_v[2]), .loopback(loop_v[2]));

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    function automatic logic get_ready(input int s);
        case (s)
            0:       return bus0.tx_ready;
            1:       return bus1.tx_ready;
            default: return bus2.tx_ready;
        endcase
    endfunction

    function automatic logic get_ser(input int s);
        case (s)
            0:       return ser_tx0;
            1:       return ser_tx1;
            default: return ser_tx2;
        endcase
    endfunction

    function automatic logic [10:0] get_rx(input int s);
        case (s)
            0:       return {bus0.rx_valid, bus0.rx_data, bus0.rx_parity_err, bus0.rx_frame_err};
            1:       return {bus1.rx_valid, bus1.rx_data, bus1.rx_parity_err, bus1.rx_frame_err};
            default: return {bus2.rx_valid, bus2.rx_data, bus2.rx_parity_err, bus2.rx_frame_err};
        endcase
    endfunction

    function automatic int qsize(input int s);
        case (s)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic push_exp(input int s, input logic [9:0] e);
        case (s)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic pop_exp(input int s, output logic [9:0] e);
        case (s)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
    endtask

    task automatic set_tx(input int s, input logic v, input logic [7:0] d);
        case (s)
            0:       begin bus0.tx_valid = v; bus0.tx_data = d; end
            1:       begin bus1.tx_valid = v; bus1.tx_data = d; end
            default: begin bus2.tx_valid = v; bus2.tx_data = d; end
        endcase
    endtask

    // Frame bits (index 0 = start bit) stretched to one entry per clock
    function automatic logic [63:0] expand(input logic [15:0] frame, input int nbits, input int cpb);
        logic [63:0] r;
        r = '1;
        for (int b = 0; b < nbits; b++)
            for (int c = 0; c < cpb; c++)
                r[b*cpb + c] = frame[b];
        return r;
    endfunction

    // Present one byte, capture ser_tx for flen cycles after accept, note first tx_ready cycle
    task automatic send_byte(input int s, input logic [7:0] d, input int flen, input bit push,
                             output logic [63:0] cap, output int rdy_at);
        int guard;
        guard = 0;
        set_tx(s, 1'b1, d);
        #1;
        while (get_ready(s) !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check("send_wait_ready", 0, 1);
        @(negedge clk);
        set_tx(s, 1'b0, 8'h00);
        if (push) push_exp(s, {d, 2'b00});
        cap    = '1;
        rdy_at = -1;
        for (int k = 1; k <= flen; k++) begin
            cap[k-1] = get_ser(s);
            if (get_ready(s) === 1'b1 && rdy_at < 0) rdy_at = k;
            if (k < flen) @(negedge clk);
        end
    endtask

    // Drive a frame onto ser_rx of instance s, then return the line high
    task automatic drive_rx(input int s, input logic [15:0] frame, input int nbits, input int cpb);
        for (int b = 0; b < nbits; b++)
            for (int c = 0; c < cpb; c++) begin
                ser_rx_v[s] = frame[b];
                @(negedge clk);
            end
        ser_rx_v[s] = 1'b1;
    endtask

    // Bounded wait for all queued RX results of instance s
    task automatic drain(input int s, input string name);
        int g;
        g = 0;
        while (qsize(s) != 0 && g < 300) begin
            @(negedge clk);
            g++;
        end
        check(name, qsize(s), 0);
    endtask

    // Monitor: every rx_valid pops one expected {data, parity_err, frame_err}
    always @(negedge clk) begin : mon
        logic [10:0] m_r;
        logic [9:0]  m_e;
        for (int s = 0; s < 3; s++) begin
            m_r = get_rx(s);
            if (m_r[10] === 1'b1) begin
                if (qsize(s) == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rx%0d_unexpected: got data %0h pe %0b fe %0b required no rx_valid",
                             s, m_r[9:2], m_r[1], m_r[0]);
                end else begin
                    pop_exp(s, m_e);
                    check($sformatf("rx%0d_frame", s), m_r[9:0], m_e);
                end
            end else if (m_r[1:0] !== 2'b00) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rx%0d_flags_idle: got %0b required 00", s, m_r[1:0]);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    initial begin
        logic [63:0] cap;
        int          rdy;
        logic [7:0]  b2b [8];
        int          acc [8];
        int          idx, gaps, guard;

        b2b = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h21, 8'h21, 8'h0A};
        rst      = 1'b1;
        ser_rx_v = 3'b111;
        loop_v   = 3'b011;
        set_tx(0, 1'b0, 8'h00);
        set_tx(1, 1'b0, 8'h00);
        set_tx(2, 1'b0, 8'h00);
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_ser_tx",   ser_tx0, 1);
        check("rst_tx_ready", bus0.tx_ready, 0);
        check("rst_tx_busy",  bus0.tx_busy, 0);
        check("rst_rx_valid", bus0.rx_valid, 0);
        check("rst_rx_data",  bus0.rx_data, 0);
        check("rst_rx_errs",  {bus0.rx_parity_err, bus0.rx_frame_err}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", bus0.tx_ready, 1);

        // Single 8N1 byte in loopback
        send_byte(0, 8'h48, 40, 1'b1, cap, rdy);
        check("t1_ser_tx_wave", cap, expand(16'(10'b1010010000), 10, 4));
        check("t1_ready_cycle", rdy, 40);
        drain(0, "t1_rx_drain");

        // Back-to-back with tx_valid held
        idx = 0; gaps = 0; guard = 0;
        set_tx(0, 1'b1, b2b[0]);
        while (idx < 8 && guard < 600) begin
            if (idx > 0 && bus0.tx_busy !== 1'b1) gaps++;
            if (bus0.tx_ready === 1'b1) begin
                acc[idx] = cyc;
                push_exp(0, {b2b[idx], 2'b00});
                idx++;
                @(negedge clk);
                if (idx < 8) set_tx(0, 1'b1, b2b[idx]);
                else         set_tx(0, 1'b0, 8'h00);
            end else begin
                @(negedge clk);
            end
            guard++;
        end
        check("b2b_accepts", idx, 8);
        for (int i = 1; i < 8; i++)
            check($sformatf("b2b_spacing_%0d", i), acc[i] - acc[i-1], 40);
        check("b2b_idle_gaps", gaps, 0);
        drain(0, "b2b_rx_drain");

        // Even parity: loopback, then a corrupted parity bit from the pin
        send_byte(1, 8'h07, 44, 1'b1, cap, rdy);
        check("par_bit_level", cap[37], 1);
        check("par_ser_tx_wave", cap, expand(16'(11'b11000001110), 11, 4));
        check("par_ready_cycle", rdy, 44);
        drain(1, "par_rx_drain");
        loop_v[1] = 1'b0;
        repeat (2) @(negedge clk);
        push_exp(1, {8'h07, 2'b10});
        drive_rx(1, 16'(11'b10000001110), 11, 4);
        drain(1, "par_err_drain");

        // Framing error followed by a held break, then recovery
        loop_v[0] = 1'b0;
        repeat (2) @(negedge clk);
        push_exp(0, {8'h55, 2'b01});
        drive_rx(0, 16'(10'b0010101010), 10, 4);
        ser_rx_v[0] = 1'b0;
        repeat (100) @(negedge clk);
        check("brk_reported", qsize(0), 0);
        ser_rx_v[0] = 1'b1;
        repeat (10) @(negedge clk);
        push_exp(0, {8'h3C, 2'b00});
        drive_rx(0, 16'(10'b1001111000), 10, 4);
        drain(0, "brk_recover_drain");

        // One-cycle glitch at 8 clk/bit, then a real frame
        ser_rx_v[2] = 1'b0;
        @(negedge clk);
        ser_rx_v[2] = 1'b1;
        repeat (20) @(negedge clk);
        push_exp(2, {8'hA3, 2'b00});
        drive_rx(2, 16'(10'b1101000110), 10, 8);
        drain(2, "glitch_drain");

        // Reset during data bit 3 of a loopback frame
        loop_v[0] = 1'b1;
        repeat (4) @(negedge clk);
        set_tx(0, 1'b1, 8'hF0);
        #1;
        check("rstmf_ready_pre", bus0.tx_ready, 1);
        @(negedge clk);
        set_tx(0, 1'b0, 8'h00);
        repeat (17) @(negedge clk);
        check("rstmf_bit3_level", ser_tx0, 0);
        rst = 1'b1;
        #1;
        check("rstmf_ready_in_rst", bus0.tx_ready, 0);
        @(negedge clk);
        check("rstmf_ser_tx_high", ser_tx0, 1);
        check("rstmf_ready_held", bus0.tx_ready, 0);
        check("rstmf_busy_clear", bus0.tx_busy, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rstmf_ready_after", bus0.tx_ready, 1);
        repeat (80) @(negedge clk);
        check("rstmf_no_rx", qsize(0), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
